// File: rtl/spi_ram_pkg.sv
// Shared command codes, frame geometry, FSM encoding and request record for
// the SPI RAM master.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_RD_WAIT,
    ST_CAPTURE,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic                 op;
    logic [DATA_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
  } req_t;

  // The command MSB is repeated as the frame's leading bit.
  function automatic logic [FRAME_BITS-1:0] mk_frame(input logic [1:0] cmd,
                                                     input logic [DATA_BITS-1:0] pl);
    return {cmd[1], cmd, pl};
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Serialises one 11-bit frame MSB-first onto MOSI and collects 8 MISO bits,
// sharing a single bit counter between the transmit and capture phases.
module spi_frame_shifter
  import spi_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [FRAME_BITS-1:0] i_frame,
  input  logic                  i_shift,
  input  logic                  i_cap_clr,
  input  logic                  i_cap,
  input  logic                  i_miso,
  output logic                  o_mosi,
  output logic                  o_tx_last,
  output logic                  o_rx_last,
  output logic [DATA_BITS-1:0]  o_rx_nxt
);

  logic [FRAME_BITS-1:0] r_sh;
  logic [3:0]            r_cnt;
  logic                  r_mosi;
  // Only 7 earlier bits are kept; the 8th goes straight out with the final sample.
  logic [DATA_BITS-2:0]  r_rx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_mosi <= 1'b0;
      r_rx   <= '0;
    end else if (i_load) begin
      r_mosi <= i_frame[FRAME_BITS-1];
      r_sh   <= {i_frame[FRAME_BITS-2:0], 1'b0};
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_mosi <= r_sh[FRAME_BITS-1];
      r_sh   <= {r_sh[FRAME_BITS-2:0], 1'b0};
      r_cnt  <= r_cnt + 4'd1;
    end else if (i_cap_clr) begin
      r_mosi <= 1'b0;
      r_cnt  <= '0;
    end else if (i_cap) begin
      r_mosi <= 1'b0;
      r_rx   <= {r_rx[DATA_BITS-3:0], i_miso};
      r_cnt  <= r_cnt + 4'd1;
    end else begin
      r_mosi <= 1'b0;
    end
  end

  assign o_mosi    = r_mosi;
  assign o_tx_last = (r_cnt == 4'(FRAME_BITS - 1));
  assign o_rx_last = (r_cnt == 4'(DATA_BITS - 1));
  assign o_rx_nxt  = {r_rx, i_miso};

endmodule

// File: rtl/spi_ram_master.sv
// Host-side SPI master: turns byte read/write requests into address and data
// frames for the SPI-slave RAM wrapper, skipping repeated address frames.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int GAP_CYC    = 1,
  parameter int RD_LAT     = 0,
  parameter bit ADDR_REUSE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [DATA_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_e               r_st;
  req_t                 r_req;
  logic [1:0]           r_cmd;
  logic [GAP_W-1:0]     r_gap;
  logic [WAIT_W-1:0]    r_wait;
  logic                 r_wr_v, r_rd_v;
  logic [DATA_BITS-1:0] r_wr_a, r_rd_a;
  logic                 r_ss_n, r_ready, r_busy, r_rsp_v;
  logic [DATA_BITS-1:0] r_rdata;

  logic                  w_hit;
  logic [1:0]            w_first_cmd;
  logic [DATA_BITS-1:0]  w_payload;
  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_load, w_shift, w_cap_clr, w_cap;
  logic                  w_tx_last, w_rx_last, w_mosi;
  logic [DATA_BITS-1:0]  w_rx_nxt;

  // Write and read addresses are cached separately; a hit starts at the data frame.
  assign w_hit = ADDR_REUSE &&
                 (req_op ? (r_wr_v && (r_wr_a == req_addr))
                         : (r_rd_v && (r_rd_a == req_addr)));
  assign w_first_cmd = req_op ? (w_hit ? CMD_WR_DATA : CMD_WR_ADDR)
                              : (w_hit ? CMD_RD_DATA : CMD_RD_ADDR);

  always_comb begin
    w_payload = r_req.addr;
    if (r_cmd == CMD_WR_DATA)      w_payload = r_req.wdata;
    else if (r_cmd == CMD_RD_DATA) w_payload = '0;
  end

  assign w_frame   = mk_frame(r_cmd, w_payload);
  assign w_load    = (r_st == ST_START);
  assign w_shift   = (r_st == ST_SHIFT) && !w_tx_last;
  assign w_cap_clr = ((r_st == ST_SHIFT) && w_tx_last && (r_cmd == CMD_RD_DATA) && (RD_LAT == 0)) ||
                     ((r_st == ST_RD_WAIT) && (r_wait == WAIT_LAST));
  assign w_cap     = (r_st == ST_CAPTURE);

  spi_frame_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_frame   (w_frame),
    .i_shift   (w_shift),
    .i_cap_clr (w_cap_clr),
    .i_cap     (w_cap),
    .i_miso    (MISO),
    .o_mosi    (w_mosi),
    .o_tx_last (w_tx_last),
    .o_rx_last (w_rx_last),
    .o_rx_nxt  (w_rx_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st    <= ST_IDLE;
      r_req   <= '0;
      r_cmd   <= CMD_WR_ADDR;
      r_gap   <= '0;
      r_wait  <= '0;
      r_wr_v  <= 1'b0;
      r_wr_a  <= '0;
      r_rd_v  <= 1'b0;
      r_rd_a  <= '0;
      r_ss_n  <= 1'b1;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_rsp_v <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_rsp_v <= 1'b0;
      case (r_st)
        ST_IDLE: begin
          if (req_valid && r_ready) begin
            r_req   <= {req_op, req_addr, req_wdata};
            r_cmd   <= w_first_cmd;
            r_ss_n  <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_st    <= ST_START;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_START: r_st <= ST_SHIFT;
        ST_SHIFT: begin
          if (w_tx_last) begin
            if (!r_cmd[0]) begin
              if (r_req.op) begin
                r_wr_v <= 1'b1;
                r_wr_a <= r_req.addr;
              end else begin
                r_rd_v <= 1'b1;
                r_rd_a <= r_req.addr;
              end
            end
            r_wait <= '0;
            if (r_cmd == CMD_RD_DATA) begin
              r_st <= (RD_LAT == 0) ? ST_CAPTURE : ST_RD_WAIT;
            end else begin
              r_st   <= ST_GAP;
              r_ss_n <= 1'b1;
              r_gap  <= '0;
              if (r_cmd == CMD_WR_DATA) begin
                r_rsp_v <= 1'b1;
                r_rdata <= '0;
              end
            end
          end
        end
        ST_RD_WAIT: begin
          if (r_wait == WAIT_LAST) r_st <= ST_CAPTURE;
          else                     r_wait <= r_wait + WAIT_W'(1);
        end
        ST_CAPTURE: begin
          if (w_rx_last) begin
            r_st    <= ST_GAP;
            r_ss_n  <= 1'b1;
            r_gap   <= '0;
            r_rsp_v <= 1'b1;
            r_rdata <= w_rx_nxt;
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_LAST) begin
            // Data frames end the transaction; an address frame is always followed by its data frame.
            if (r_cmd[0]) begin
              r_st    <= ST_IDLE;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_st   <= ST_START;
              r_ss_n <= 1'b0;
              r_cmd  <= {r_cmd[1], 1'b1};
            end
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_v;
  assign rsp_rdata = r_rdata;
  assign busy      = r_busy;
  assign SS_n      = r_ss_n;
  assign MOSI      = w_mosi;

endmodule

// File: tb/tb_spi_ram_master.sv
// Randomised bench for spi_ram_master: a slave+RAM model answers on MISO and
// a transaction-level model predicts the SS_n/MOSI waveform cycle by cycle.
module tb_spi_ram_master;

  localparam int GAP_CYC    = 1;
  localparam int RD_LAT     = 0;
  localparam bit ADDR_REUSE = 1'b1;

  localparam logic [1:0] T_WR_ADDR = 2'b00;
  localparam logic [1:0] T_WR_DATA = 2'b01;
  localparam logic [1:0] T_RD_ADDR = 2'b10;
  localparam logic [1:0] T_RD_DATA = 2'b11;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_valid = 1'b0, req_op = 1'b0, MISO = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, busy, SS_n, MOSI;
  logic [7:0] rsp_rdata;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  spi_ram_master #(.GAP_CYC(GAP_CYC), .RD_LAT(RD_LAT), .ADDR_REUSE(ADDR_REUSE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] pre(input logic [7:0] a);
    return 8'((a * 8'd29) ^ 8'hA7);
  endfunction

  // ---------------- slave + RAM model (decodes frames off the pins) -------
  logic [7:0]  s_mem [256];
  bit          s_wr  [256];
  logic [7:0]  s_wa = '0, s_ra = '0, s_rd = '0;
  logic [10:0] s_sh = '0;
  int          s_j  = -1;

  always @(negedge clk) begin
    if (SS_n !== 1'b0) s_j = -1;
    else begin
      s_j = s_j + 1;
      if (s_j >= 1 && s_j <= 11) s_sh = {s_sh[9:0], MOSI};
      if (s_j == 11) begin
        case (s_sh[9:8])
          T_WR_ADDR: s_wa = s_sh[7:0];
          T_WR_DATA: begin s_mem[s_wa] = s_sh[7:0]; s_wr[s_wa] = 1'b1; end
          T_RD_ADDR: s_ra = s_sh[7:0];
          default:   s_rd = s_wr[s_ra] ? s_mem[s_ra] : pre(s_ra);
        endcase
      end
    end
    if (s_j >= 12 + RD_LAT && s_j <= 19 + RD_LAT) MISO = s_rd[19 + RD_LAT - s_j];
    else                                          MISO = 1'($urandom);
  end

  // ---------------- transaction-level reference model ---------------------
  typedef struct packed { logic ss; logic mosi; logic mchk; logic rsp; } ev_t;
  ev_t        exp_q[$];
  logic [7:0] ref_mem [256];
  bit         m_wr_v = 0, m_rd_v = 0;
  logic [7:0] m_wr_a = '0, m_rd_a = '0, m_rdata = '0;

  function automatic ev_t ev(input logic ss, input logic mosi, input logic mchk, input logic rsp);
    ev_t e;
    e.ss = ss; e.mosi = mosi; e.mchk = mchk; e.rsp = rsp;
    return e;
  endfunction

  task automatic add_frame(input logic [1:0] cmd, input logic [7:0] pl, input bit last);
    logic [10:0] f;
    f = {cmd[1], cmd, pl};
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 10; i >= 0; i--) exp_q.push_back(ev(1'b0, f[i], 1'b1, 1'b0));
    if (cmd == T_RD_DATA)
      for (int i = 0; i < RD_LAT + 8; i++) exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0));
    for (int g = 0; g < GAP_CYC; g++) exp_q.push_back(ev(1'b1, 1'b0, 1'b1, last && g == 0));
  endtask

  // Caller is always positioned at a falling edge. exp_lat=0 skips the latency check.
  task automatic run_req(input bit op, input logic [7:0] a, input logic [7:0] d,
                         input bit scramble, input bit abort, input int exp_lat);
    bit         hit;
    int         abort_k, lat_obs, g;
    logic [7:0] exp_rd;
    g = 0;
    while (req_ready !== 1'b1 && g < 64) begin @(negedge clk); g++; end
    chk("req_ready_wait", req_ready, 1);

    exp_q.delete();
    abort_k = -1;
    lat_obs = -1;
    hit = ADDR_REUSE && (op ? (m_wr_v && m_wr_a == a) : (m_rd_v && m_rd_a == a));
    if (!hit) begin
      add_frame(op ? T_WR_ADDR : T_RD_ADDR, a, 1'b0);
      if (op) begin m_wr_v = 1; m_wr_a = a; end
      else    begin m_rd_v = 1; m_rd_a = a; end
    end
    if (abort) abort_k = exp_q.size() + 1 + 5;
    add_frame(op ? T_WR_DATA : T_RD_DATA, op ? d : 8'h00, 1'b1);
    exp_rd = op ? 8'h00 : ref_mem[a];

    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      req_valid = scramble;
      if (scramble) begin
        req_op = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
      end
      chk("ss_n", SS_n, exp_q[k].ss);
      if (exp_q[k].mchk) chk("mosi", MOSI, exp_q[k].mosi);
      chk("rsp_valid", rsp_valid, exp_q[k].rsp);
      chk("busy", busy, 1);
      chk("req_ready_busy", req_ready, 0);
      if (exp_q[k].rsp) chk("rsp_rdata", rsp_rdata, exp_rd);
      if (rsp_valid === 1'b1 && lat_obs < 0) lat_obs = k + 1;
      if (k == abort_k) begin rst_n = 1'b0; break; end
    end

    if (abort) begin
      @(negedge clk);
      chk("rst_ss_n", SS_n, 1);
      chk("rst_mosi", MOSI, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_rdata", rsp_rdata, 0);
      rst_n = 1'b1;
      req_valid = 1'b0;
      m_wr_v = 0; m_rd_v = 0; m_rdata = '0;
    end else begin
      @(negedge clk);
      chk("idle_ss_n", SS_n, 1);
      chk("idle_mosi", MOSI, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_rdata_hold", rsp_rdata, exp_rd);
      if (exp_lat > 0) chk("latency", 16'(lat_obs), 16'(exp_lat));
      if (op) ref_mem[a] = d;
      m_rdata = exp_rd;
    end
  endtask

  logic [7:0] pool [4];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = pre(8'(i));
    rst_n = 1'b0; req_valid = 1'b1; req_addr = 8'h55;
    repeat (3) @(negedge clk);
    chk("reset_ss_n", SS_n, 1);
    chk("reset_mosi", MOSI, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rdata", rsp_rdata, 0);
    rst_n = 1'b1; req_valid = 1'b0;

    run_req(1'b1, 8'hAA, 8'h99, 1'b0, 1'b0, 26);  // write
    run_req(1'b0, 8'hAA, 8'h00, 1'b0, 1'b0, 34);  // read
    run_req(1'b0, 8'hAA, 8'h00, 1'b0, 1'b0, 21);  // read, address reused
    run_req(1'b0, 8'hDB, 8'h00, 1'b0, 1'b0, 34);
    run_req(1'b1, 8'hDB, 8'h3C, 1'b0, 1'b0, 26);  // separate write cache
    run_req(1'b0, 8'hDB, 8'h00, 1'b0, 1'b0, 21);
    run_req(1'b1, 8'hAA, 8'h17, 1'b0, 1'b1, 0);   // reset mid WR_DATA
    run_req(1'b1, 8'hAA, 8'h42, 1'b0, 1'b0, 26);  // caches lost to reset
    run_req(1'b0, 8'hAA, 8'h00, 1'b0, 1'b0, 34);
    run_req(1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 34);  // valid held, fields churn
    run_req(1'b1, 8'h10, 8'h5A, 1'b1, 1'b0, 26);
    run_req(1'b1, 8'h10, 8'hC3, 1'b0, 1'b0, 13);

    for (int i = 0; i < 4; i++) pool[i] = 8'($urandom);
    for (int n = 0; n < 40; n++)
      run_req(1'($urandom), pool[$urandom_range(3)], 8'($urandom),
              1'($urandom), 1'b0, 0);
    req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
